// File: rtl/codec_8b10b.sv
// 8b/10b encoder and decoder channels, each with its own running disparity.
// Both channels register their results on the strobe edge and hold otherwise.
module codec_8b10b (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_en,
    input  logic [8:0] enc_din,
    output logic [9:0] enc_dout,
    output logic       enc_rd,
    input  logic       dec_en,
    input  logic [9:0] dec_din,
    output logic [8:0] dec_dout,
    output logic       dec_code_err,
    output logic       dec_disp_err,
    output logic       dec_rd
);

    // Table literals are written abcdei / fghj with 'a' (or 'f') as the MSB.
    function automatic logic [5:0] rev6(input logic [5:0] p);
        return {p[0], p[1], p[2], p[3], p[4], p[5]};
    endfunction

    function automatic logic [3:0] rev4(input logic [3:0] p);
        return {p[0], p[1], p[2], p[3]};
    endfunction

    // 5b/6b table, RD- column.
    function automatic logic [5:0] t6(input logic [4:0] x);
        case (x)
            5'd0:    return 6'b100111;
            5'd1:    return 6'b011101;
            5'd2:    return 6'b101101;
            5'd3:    return 6'b110001;
            5'd4:    return 6'b110101;
            5'd5:    return 6'b101001;
            5'd6:    return 6'b011001;
            5'd7:    return 6'b111000;
            5'd8:    return 6'b111001;
            5'd9:    return 6'b100101;
            5'd10:   return 6'b010101;
            5'd11:   return 6'b110100;
            5'd12:   return 6'b001101;
            5'd13:   return 6'b101100;
            5'd14:   return 6'b011100;
            5'd15:   return 6'b010111;
            5'd16:   return 6'b011011;
            5'd17:   return 6'b100011;
            5'd18:   return 6'b010011;
            5'd19:   return 6'b110010;
            5'd20:   return 6'b001011;
            5'd21:   return 6'b101010;
            5'd22:   return 6'b011010;
            5'd23:   return 6'b111010;
            5'd24:   return 6'b110011;
            5'd25:   return 6'b100110;
            5'd26:   return 6'b010110;
            5'd27:   return 6'b110110;
            5'd28:   return 6'b001110;
            5'd29:   return 6'b101110;
            5'd30:   return 6'b011110;
            default: return 6'b101011;
        endcase
    endfunction

    // 3b/4b table, RD- column (primary D.x.7 form).
    function automatic logic [3:0] t4(input logic [2:0] y);
        case (y)
            3'd0:    return 4'b1011;
            3'd1:    return 4'b1001;
            3'd2:    return 4'b0101;
            3'd3:    return 4'b1100;
            3'd4:    return 4'b1101;
            3'd5:    return 4'b1010;
            3'd6:    return 4'b0110;
            default: return 4'b1110;
        endcase
    endfunction

    // RD after a code group: sign of the last unbalanced sub-block.
    function automatic logic next_rd(input logic [9:0] c, input logic rd);
        int ones4;
        int ones6;
        ones4 = $countones(c[9:6]);
        ones6 = $countones(c[5:0]);
        if (ones4 != 2)
            return (ones4 > 2);
        if (ones6 != 3)
            return (ones6 > 3);
        return rd;
    endfunction

    // Full encoder; K with an unlisted value falls back to the D code.
    function automatic logic [9:0] encode(input logic [8:0] sym, input logic rd);
        logic [4:0] x;
        logic [2:0] y;
        logic       k28;
        logic       kx7;
        logic       unbal6;
        logic       unbal4;
        logic       rd_mid;
        logic       a7;
        logic       inv4;
        logic [5:0] s6;
        logic [3:0] s4;
        x   = sym[4:0];
        y   = sym[7:5];
        k28 = sym[8] && (x == 5'd28);
        kx7 = sym[8] && (y == 3'd7) &&
              (x == 5'd23 || x == 5'd27 || x == 5'd29 || x == 5'd30);
        s6     = k28 ? 6'b001111 : t6(x);
        unbal6 = ($countones(s6) != 3);
        // D.7 is balanced yet still has distinct RD- and RD+ forms
        if (rd && (unbal6 || (!k28 && x == 5'd7)))
            s6 = ~s6;
        rd_mid = rd ^ unbal6;
        a7 = (y == 3'd7) &&
             (k28 || kx7 ||
              (!rd_mid && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
              ( rd_mid && (x == 5'd11 || x == 5'd13 || x == 5'd14)));
        s4     = a7 ? 4'b0111 : t4(y);
        unbal4 = (y == 3'd0 || y == 3'd4 || y == 3'd7);
        // K28 balanced trailers are mirrored relative to the D forms
        if (k28 && (y == 3'd1 || y == 3'd2 || y == 3'd5 || y == 3'd6))
            inv4 = !rd_mid;
        else
            inv4 = rd_mid && (unbal4 || y == 3'd3);
        if (inv4)
            s4 = ~s4;
        return {rev4(s4), rev6(s6)};
    endfunction

    function automatic logic [4:0] dec6(input logic [5:0] p);
        logic [4:0] x;
        logic [5:0] c;
        x = 5'd0;
        for (int i = 0; i < 32; i++) begin
            c = t6(5'(i));
            if (p == c || (p == ~c && ($countones(c) != 3 || i == 7)))
                x = 5'(i);
        end
        return x;
    endfunction

    function automatic logic [2:0] dec4(input logic [3:0] p);
        case (p)
            4'b1011, 4'b0100:                   return 3'd0;
            4'b1001:                            return 3'd1;
            4'b0101:                            return 3'd2;
            4'b1100, 4'b0011:                   return 3'd3;
            4'b1101, 4'b0010:                   return 3'd4;
            4'b1010:                            return 3'd5;
            4'b0110:                            return 3'd6;
            4'b1110, 4'b0001, 4'b0111, 4'b1000: return 3'd7;
            default:                            return 3'd0;
        endcase
    endfunction

    logic [9:0] enc_code;
    logic       enc_rd_next;

    always_comb begin
        enc_code    = encode(enc_din, enc_rd);
        enc_rd_next = next_rd(enc_code, enc_rd);
    end

    logic [5:0] p6;
    logic [3:0] p4;
    logic [3:0] q4;
    logic       k6;
    logic [4:0] x_c;
    logic [2:0] y_c;
    logic       k_c;
    logic [8:0] cand;
    logic       ok_neg;
    logic       ok_pos;
    logic       code_err_next;
    logic       disp_err_next;
    logic       dec_rd_next;

    // Decode a candidate symbol, then accept it only if re-encoding from
    // some RD reproduces the received pattern exactly.
    always_comb begin
        p6   = rev6(dec_din[5:0]);
        p4   = rev4(dec_din[9:6]);
        k6   = (p6 == 6'b001111) || (p6 == 6'b110000);
        x_c  = k6 ? 5'd28 : dec6(p6);
        q4   = (p6 == 6'b110000) ? ~p4 : p4;
        y_c  = dec4(q4);
        k_c  = k6 || ((p4 == 4'b0111 || p4 == 4'b1000) &&
                      (x_c == 5'd23 || x_c == 5'd27 || x_c == 5'd29 || x_c == 5'd30));
        cand = {k_c, y_c, x_c};
        ok_neg        = (encode(cand, 1'b0) == dec_din);
        ok_pos        = (encode(cand, 1'b1) == dec_din);
        code_err_next = !(ok_neg || ok_pos);
        disp_err_next = !code_err_next && !(dec_rd ? ok_pos : ok_neg);
        dec_rd_next   = next_rd(dec_din, dec_rd);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_dout <= 10'h000;
            enc_rd   <= 1'b0;
        end else if (enc_en) begin
            enc_dout <= enc_code;
            enc_rd   <= enc_rd_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_dout     <= 9'h000;
            dec_code_err <= 1'b0;
            dec_disp_err <= 1'b0;
            dec_rd       <= 1'b0;
        end else if (dec_en) begin
            dec_dout     <= cand;
            dec_code_err <= code_err_next;
            dec_disp_err <= disp_err_next;
            dec_rd       <= dec_rd_next;
        end
    end

endmodule

// File: tb/tb_codec_8b10b.sv
// Directed and table-driven checks for codec_8b10b; the reference encoder
// below is built from explicit RD-/RD+ columns of the standard tables.
module tb_codec_8b10b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enc_en;
    logic [8:0] enc_din;
    logic [9:0] enc_dout;
    logic       enc_rd;
    logic       dec_en;
    logic [9:0] dec_din;
    logic [8:0] dec_dout;
    logic       dec_code_err;
    logic       dec_disp_err;
    logic       dec_rd;

    codec_8b10b dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enc_en       (enc_en),
        .enc_din      (enc_din),
        .enc_dout     (enc_dout),
        .enc_rd       (enc_rd),
        .dec_en       (dec_en),
        .dec_din      (dec_din),
        .dec_dout     (dec_dout),
        .dec_code_err (dec_code_err),
        .dec_disp_err (dec_disp_err),
        .dec_rd       (dec_rd)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_err = 0;
    bit         exp_ok [0:1][0:1023];
    logic [8:0] exp_sym [0:1023];
    logic       mrd;
    logic [8:0] prev_sym;
    bit         have_prev;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // {RD- form, RD+ form}, abcdei with 'a' as MSB
    function automatic logic [11:0] tb6(input int x);
        case (x)
            0:  return {6'b100111, 6'b011000};
            1:  return {6'b011101, 6'b100010};
            2:  return {6'b101101, 6'b010010};
            3:  return {6'b110001, 6'b110001};
            4:  return {6'b110101, 6'b001010};
            5:  return {6'b101001, 6'b101001};
            6:  return {6'b011001, 6'b011001};
            7:  return {6'b111000, 6'b000111};
            8:  return {6'b111001, 6'b000110};
            9:  return {6'b100101, 6'b100101};
            10: return {6'b010101, 6'b010101};
            11: return {6'b110100, 6'b110100};
            12: return {6'b001101, 6'b001101};
            13: return {6'b101100, 6'b101100};
            14: return {6'b011100, 6'b011100};
            15: return {6'b010111, 6'b101000};
            16: return {6'b011011, 6'b100100};
            17: return {6'b100011, 6'b100011};
            18: return {6'b010011, 6'b010011};
            19: return {6'b110010, 6'b110010};
            20: return {6'b001011, 6'b001011};
            21: return {6'b101010, 6'b101010};
            22: return {6'b011010, 6'b011010};
            23: return {6'b111010, 6'b000101};
            24: return {6'b110011, 6'b001100};
            25: return {6'b100110, 6'b100110};
            26: return {6'b010110, 6'b010110};
            27: return {6'b110110, 6'b001001};
            28: return {6'b001110, 6'b001110};
            29: return {6'b101110, 6'b010001};
            30: return {6'b011110, 6'b100001};
            default: return {6'b101011, 6'b010100};
        endcase
    endfunction

    function automatic logic [7:0] tb4d(input int y);
        case (y)
            0: return {4'b1011, 4'b0100};
            1: return {4'b1001, 4'b1001};
            2: return {4'b0101, 4'b0101};
            3: return {4'b1100, 4'b0011};
            4: return {4'b1101, 4'b0010};
            5: return {4'b1010, 4'b1010};
            6: return {4'b0110, 4'b0110};
            default: return {4'b1110, 4'b0001};
        endcase
    endfunction

    function automatic logic [7:0] tb4k(input int y);
        case (y)
            0: return {4'b1011, 4'b0100};
            1: return {4'b0110, 4'b1001};
            2: return {4'b1010, 4'b0101};
            3: return {4'b1100, 4'b0011};
            4: return {4'b1101, 4'b0010};
            5: return {4'b0101, 4'b1010};
            6: return {4'b1001, 4'b0110};
            default: return {4'b0111, 4'b1000};
        endcase
    endfunction

    function automatic logic sub_rd(input int ones, input int half, input logic rd);
        if (ones > half) return 1'b1;
        if (ones < half) return 1'b0;
        return rd;
    endfunction

    function automatic logic [8:0] sym_of(input int i);
        if (i < 256) return 9'(i);
        case (i - 256)
            8:  return 9'h1F7;
            9:  return 9'h1FB;
            10: return 9'h1FD;
            11: return 9'h1FE;
            default: return {1'b1, 3'(i - 256), 5'd28};
        endcase
    endfunction

    // Returns {rd after symbol, 10-bit code in port bit order}.
    function automatic logic [10:0] model_enc(input logic [8:0] s, input logic rd);
        int         x;
        int         y;
        logic       k28;
        logic       kx7;
        logic       r6;
        logic       r4;
        logic [11:0] t6;
        logic [7:0] t4;
        logic [5:0] c6;
        logic [3:0] c4;
        x   = int'(s[4:0]);
        y   = int'(s[7:5]);
        k28 = s[8] && x == 28;
        kx7 = s[8] && y == 7 && (x == 23 || x == 27 || x == 29 || x == 30);
        t6  = tb6(x);
        if (k28) c6 = rd ? 6'b110000 : 6'b001111;
        else     c6 = rd ? t6[5:0] : t6[11:6];
        r6 = sub_rd($countones(c6), 3, rd);
        if (k28)
            t4 = tb4k(y);
        else if (y == 7 && (kx7 || (!r6 && (x == 17 || x == 18 || x == 20)) ||
                            (r6 && (x == 11 || x == 13 || x == 14))))
            t4 = {4'b0111, 4'b1000};
        else
            t4 = tb4d(y);
        c4 = r6 ? t4[3:0] : t4[7:4];
        r4 = sub_rd($countones(c4), 2, r6);
        return {r4, c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
    endfunction

    function automatic logic exp_rd(input logic [9:0] p, input logic rd);
        return sub_rd($countones(p[9:6]), 2, sub_rd($countones(p[5:0]), 3, rd));
    endfunction

    task automatic step(input logic [8:0] s);
        logic [10:0] m;
        m       = model_enc(s, mrd);
        enc_din = s;
        dec_din = enc_dout;
        tick();
        check("rt_enc_dout", enc_dout, m[9:0]);
        check("rt_enc_rd", enc_rd, m[10]);
        if (have_prev) begin
            check("rt_dec_dout", dec_dout, prev_sym);
            check("rt_dec_rd", dec_rd, mrd);
            check("rt_code_err", dec_code_err, 1'b0);
            check("rt_disp_err", dec_disp_err, 1'b0);
        end
        prev_sym  = s;
        have_prev = 1'b1;
        mrd       = m[10];
    endtask

    initial begin
        logic [10:0] m;
        logic [9:0]  p;
        rst_n   = 1'b0;
        enc_en  = 1'b0;
        dec_en  = 1'b0;
        enc_din = 9'h000;
        dec_din = 10'h000;
        for (int i = 0; i < 268; i++) begin
            for (int r = 0; r < 2; r++) begin
                m = model_enc(sym_of(i), r[0]);
                exp_ok[r][m[9:0]] = 1'b1;
                exp_sym[m[9:0]]   = sym_of(i);
            end
        end

        #7;
        check("rst_enc_dout", enc_dout, 10'h000);
        check("rst_enc_rd", enc_rd, 1'b0);
        check("rst_dec_dout", dec_dout, 9'h000);
        check("rst_code_err", dec_code_err, 1'b0);
        check("rst_disp_err", dec_disp_err, 1'b0);
        check("rst_dec_rd", dec_rd, 1'b0);
        rst_n = 1'b1;

        // K28.5 from RD- then RD+, then hold with the strobe low
        enc_en = 1'b1; enc_din = 9'h1BC;
        tick();
        check("k285_neg", enc_dout, 10'h17C);
        check("k285_neg_rd", enc_rd, 1'b1);
        tick();
        check("k285_pos", enc_dout, 10'h283);
        check("k285_pos_rd", enc_rd, 1'b0);
        enc_en = 1'b0; enc_din = 9'h000;
        tick();
        check("enc_hold", enc_dout, 10'h283);

        // Balanced codes, illegal K fallback, alternate D.x.7 and Kx.7 forms
        do_reset();
        enc_en = 1'b1; enc_din = 9'h000;
        tick();
        check("d00", enc_dout, 10'h0B9);
        check("d00_rd", enc_rd, 1'b0);
        enc_din = 9'h0B5;
        tick();
        check("d215", enc_dout, 10'h155);
        check("d215_rd", enc_rd, 1'b0);
        enc_din = 9'h100;
        tick();
        check("illegal_k", enc_dout, 10'h0B9);
        check("illegal_k_rd", enc_rd, 1'b0);
        enc_din = 9'h0F1;
        tick();
        check("d177_a7", enc_dout, 10'h3B1);
        check("d177_rd", enc_rd, 1'b1);
        enc_din = 9'h0EB;
        tick();
        check("d117_a7", enc_dout, 10'h04B);
        check("d117_rd", enc_rd, 1'b0);
        enc_din = 9'h1FC;
        tick();
        check("k287", enc_dout, 10'h07C);
        enc_din = 9'h1F7;
        tick();
        check("k237", enc_dout, 10'h057);
        check("k237_rd", enc_rd, 1'b0);
        enc_en = 1'b0;

        // Decoder disparity error, code errors and hold
        do_reset();
        dec_en = 1'b1; dec_din = 10'h283;
        tick();
        check("derr_dout", dec_dout, 9'h1BC);
        check("derr_code", dec_code_err, 1'b0);
        check("derr_disp", dec_disp_err, 1'b1);
        check("derr_rd", dec_rd, 1'b0);
        dec_din = 10'h17C;
        tick();
        check("dok_disp", dec_disp_err, 1'b0);
        check("dok_rd", dec_rd, 1'b1);
        dec_din = 10'h000;
        tick();
        check("zeros_code", dec_code_err, 1'b1);
        check("zeros_rd", dec_rd, 1'b0);
        dec_din = 10'h3FF;
        tick();
        check("ones_code", dec_code_err, 1'b1);
        check("ones_rd", dec_rd, 1'b1);
        dec_en = 1'b0; dec_din = 10'h283;
        tick();
        check("dec_hold_code", dec_code_err, 1'b1);
        check("dec_hold_rd", dec_rd, 1'b1);

        // Round trip of every symbol from each RD, encoder feeding decoder
        do_reset();
        enc_en = 1'b1; dec_en = 1'b1;
        mrd = 1'b0; have_prev = 1'b0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 268; i++) begin
                if (mrd != r[0]) step(9'h1BC);
                step(sym_of(i));
            end
        end
        step(9'h1BC);
        enc_en = 1'b0;

        // All 1024 patterns at each decoder RD, primed by a K28.5 form
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 1024; i++) begin
                p = 10'(i);
                dec_din = (r == 1) ? 10'h17C : 10'h283;
                tick();
                dec_din = p;
                tick();
                check("sw_code_err", dec_code_err, !(exp_ok[0][i] || exp_ok[1][i]));
                check("sw_dec_rd", dec_rd, exp_rd(p, r[0]));
                if (exp_ok[0][i] || exp_ok[1][i]) begin
                    check("sw_dec_dout", dec_dout, exp_sym[i]);
                    check("sw_disp_err", dec_disp_err, !exp_ok[r][i]);
                end
            end
        end

        // Asynchronous reset while both channels sit at RD+
        do_reset();
        enc_en = 1'b1; dec_en = 1'b1; enc_din = 9'h1BC; dec_din = 10'h17C;
        tick();
        check("pre_enc_rd", enc_rd, 1'b1);
        check("pre_dec_rd", dec_rd, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_enc_dout", enc_dout, 10'h000);
        check("arst_enc_rd", enc_rd, 1'b0);
        check("arst_dec_dout", dec_dout, 9'h000);
        check("arst_dec_rd", dec_rd, 1'b0);
        check("arst_disp", dec_disp_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_k285", enc_dout, 10'h17C);
        check("post_rst_enc_rd", enc_rd, 1'b1);
        check("post_rst_disp", dec_disp_err, 1'b0);
        check("post_rst_dec_rd", dec_rd, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
